// File: rtl/dff_pipe_if.sv
// Handshake bundle for dff_pipe: upstream valid/ready/data, downstream valid/ready/data,
// flush and occupancy. The master drives the inputs of the pipe; the slave is the pipe itself.
interface dff_pipe_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Q_out;
    logic [WIDTH-1:0] Qb_out;
    logic [CW-1:0]    occupancy;

    modport master (
        output flush,
        output in_valid,
        output d_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  Q_out,
        input  Qb_out,
        input  occupancy
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  d_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output Q_out,
        output Qb_out,
        output occupancy
    );
endinterface

// File: rtl/dff_pipe.sv
// Elastic register pipeline: DEPTH stages of WIDTH-bit registers with per-stage valid,
// backpressure via a combinational ready chain, bubble collapse and synchronous flush.
module dff_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input logic      clock,
    input logic      reset,
    dff_pipe_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] drain;
    logic [CW-1:0]    occ;

    // A stage is ready when it is empty or its contents move on this cycle.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = bus.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = !valid_q[i] | rdy[i+1];
        end
    end

    always_comb begin
        load    = '0;
        drain   = '0;
        load[0] = bus.in_valid & rdy[0] & !bus.flush;
        for (int i = 1; i < DEPTH; i++) begin
            load[i] = valid_q[i-1] & rdy[i] & !bus.flush;
        end
        for (int i = 0; i < DEPTH; i++) begin
            drain[i] = valid_q[i] & rdy[i+1] & !bus.flush;
        end
    end

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.flush) begin
                valid_d[i] = 1'b0;
            end else if (load[i]) begin
                valid_d[i] = 1'b1;
            end else if (drain[i]) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    // Data only moves on a transfer; empty or flushed stages keep stale contents.
    always_comb begin
        data_d = data_q;
        if (load[0]) begin
            data_d[0] = bus.d_in;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (load[i]) begin
                data_d[i] = data_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ = occ + CW'(valid_q[i]);
        end
    end

    assign bus.in_ready  = rdy[0] & !bus.flush;
    assign bus.out_valid = valid_q[DEPTH-1] & !bus.flush;
    assign bus.Q_out     = data_q[DEPTH-1];
    assign bus.Qb_out    = ~data_q[DEPTH-1];
    assign bus.occupancy = occ;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe (WIDTH=8, DEPTH=4): accepted words feed a scoreboard queue,
// a monitor pops and compares on every consumed output.
module tb_dff_pipe;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dff_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    int run_len = 0;
    int max_run = 0;
    logic [7:0] sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Present v and hold until accepted; in_valid stays high afterwards.
    task automatic push(input logic [7:0] v);
        int k;
        bus.d_in     = v;
        bus.in_valid = 1'b1;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            tick();
            k++;
        end
        if (k == 50) check("push_timeout", 32'd1, 32'd0);
        tick();
    endtask

    // Monitor/scoreboard: pop before push so ordering within one sample is fixed.
    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge clock);
            if (bus.out_valid && bus.out_ready) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got word %0h, required none", bus.Q_out);
                end else begin
                    exp = sb_q.pop_front();
                    check("out_data", {24'd0, bus.Q_out}, {24'd0, exp});
                    check("out_inv", {24'd0, bus.Qb_out}, {24'd0, ~exp});
                end
            end else begin
                run_len = 0;
            end
            if (bus.flush || !reset) begin
                sb_q.delete();
            end else if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back(bus.d_in);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int quiet;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.d_in      = '0;
        bus.out_ready = 1'b1;
        #12 reset = 1'b1;
        tick();

        // Reset mid-operation with two words in flight.
        bus.out_ready = 1'b0;
        push(8'h77);
        push(8'h78);
        idle(1);
        check("pre_reset_occ", 32'(bus.occupancy), 32'd2);
        #2 reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_q", 32'(bus.Q_out), 32'h00);
        check("rst_qb", 32'(bus.Qb_out), 32'hFF);
        check("rst_occ", 32'(bus.occupancy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        #2 reset = 1'b1;
        tick();

        // Latency: A5 appears after exactly four edges, for one cycle.
        bus.d_in     = 8'hA5;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("lat_occ", 32'(bus.occupancy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("lat_valid", 32'(bus.out_valid), (i == 3) ? 32'd1 : 32'd0);
            if (i == 3) begin
                check("lat_q", 32'(bus.Q_out), 32'hA5);
                check("lat_qb", 32'(bus.Qb_out), 32'h5A);
            end
        end
        @(negedge clock);
        check("lat_one_cycle", 32'(bus.out_valid), 32'd0);
        tick();

        // Backpressure: 01..04 fill the pipe, 05 waits.
        bus.out_ready = 1'b0;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        bus.d_in = 8'h05;
        #1;
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_occ", 32'(bus.occupancy), 32'd4);
        tick();
        check("bp_stall_q", 32'(bus.Q_out), 32'h01);
        check("bp_stall_rdy", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_order", 32'(bus.Q_out), 32'(i + 1));
            if (i == 0) begin
                check("bp_full_rdy", 32'(bus.in_ready), 32'd1);
                check("bp_full_occ", 32'(bus.occupancy), 32'd4);
            end
            tick();
            if (i == 0) bus.in_valid = 1'b0;
        end

        // Streaming 10..1F at full rate.
        idle(2);
        max_run = 0;
        for (int i = 0; i < 16; i++) begin
            bus.d_in     = 8'h10 + 8'(i);
            bus.in_valid = 1'b1;
            check("stream_rdy", 32'(bus.in_ready), 32'd1);
            tick();
        end
        idle(6);
        check("stream_run", 32'(max_run), 32'd16);

        // Flush with three words in flight.
        bus.out_ready = 1'b0;
        push(8'hE1);
        push(8'hE2);
        push(8'hE3);
        idle(4);
        check("fl_pre_occ", 32'(bus.occupancy), 32'd3);
        check("fl_pre_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        bus.d_in      = 8'hEE;
        bus.in_valid  = 1'b1;
        #1;
        check("fl_in_ready", 32'(bus.in_ready), 32'd0);
        check("fl_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_occ", 32'(bus.occupancy), 32'd0);
        check("fl_stale_q", 32'(bus.Q_out), 32'hE1);
        quiet = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (bus.out_valid) quiet++;
        end
        check("fl_silent", 32'(quiet), 32'd0);
        tick();
        push(8'hF0);
        idle(6);

        // Bubble collapse: C1, two idle cycles, C2 while stalled.
        bus.out_ready = 1'b0;
        push(8'hC1);
        idle(2);
        push(8'hC2);
        idle(2);
        check("bub_occ", 32'(bus.occupancy), 32'd2);
        check("bub_head", 32'(bus.Q_out), 32'hC1);
        bus.out_ready = 1'b1;
        @(negedge clock);
        check("bub_first", 32'(bus.Q_out), 32'hC1);
        @(negedge clock);
        check("bub_second_v", 32'(bus.out_valid), 32'd1);
        check("bub_second", 32'(bus.Q_out), 32'hC2);
        @(negedge clock);
        check("bub_drained", 32'(bus.out_valid), 32'd0);
        tick();

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
